// File: rtl/branch_unit.sv
// Execute-stage branch/jump resolution with a bimodal predictor table read by fetch.
// Optional statistics counters are enabled by defining BRANCH_UNIT_STATS_EN.
module branch_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CTR_BITS  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_flush,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
`ifdef BRANCH_UNIT_STATS_EN
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred,
`endif
    output logic            br_valid,
    output logic            br_taken,
    output logic            br_redirect,
    output logic [XLEN-1:0] br_target,
    output logic            br_illegal
);

    localparam int IDX = $clog2(BHT_DEPTH);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

    function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] ctr,
                                                     input logic up);
        logic [CTR_BITS-1:0] res;
        if (up) begin
            res = (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1);
        end else begin
            res = (ctr == {CTR_BITS{1'b0}}) ? ctr : ctr - CTR_BITS'(1);
        end
        return res;
    endfunction

    logic [CTR_BITS-1:0] bht_q [BHT_DEPTH];

    logic            valid_q, valid_d;
    logic            taken_q, taken_d;
    logic            redirect_q, redirect_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] target_q, target_d;

    logic            act_s;
    logic            cond_s;
    logic            cond_legal_s;
    logic            bht_upd_s;
    logic [IDX-1:0]  f_idx_s;
    logic [IDX-1:0]  ex_idx_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] pc_plus_imm_s;
    logic [XLEN-1:0] jalr_tgt_s;
    logic            unused_s;

    assign act_s         = ex_valid & ~ex_flush;
    assign f_idx_s       = f_pc[IDX+1:2];
    assign ex_idx_s      = ex_pc[IDX+1:2];
    assign pc_plus4_s    = ex_pc + XLEN'(4);
    assign pc_plus_imm_s = ex_pc + ex_imm;
    assign jalr_tgt_s    = (ex_rs1 + ex_imm) & ~XLEN'(1);
    assign unused_s      = ^{f_pc[XLEN-1:IDX+2], f_pc[1:0]};

    // Lookup reads the stored counter only; an update in this cycle is not forwarded.
    assign f_pred_taken  = bht_q[f_idx_s][CTR_BITS-1];

    // Branch condition evaluation from funct3.
    always_comb begin
        cond_s       = 1'b0;
        cond_legal_s = 1'b1;
        case (ex_funct3)
            3'b000:  cond_s = (ex_rs1 == ex_rs2);
            3'b001:  cond_s = (ex_rs1 != ex_rs2);
            3'b100:  cond_s = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  cond_s = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  cond_s = (ex_rs1 <  ex_rs2);
            3'b111:  cond_s = (ex_rs1 >= ex_rs2);
            default: cond_legal_s = 1'b0;
        endcase
    end

    // Result next-state and predictor update enable.
    always_comb begin
        valid_d    = 1'b0;
        taken_d    = 1'b0;
        redirect_d = 1'b0;
        illegal_d  = 1'b0;
        target_d   = target_q;
        bht_upd_s  = 1'b0;
        if (act_s) begin
            valid_d = 1'b1;
            case (ex_opcode)
                OP_JAL: begin
                    taken_d    = 1'b1;
                    redirect_d = 1'b1;
                    target_d   = pc_plus_imm_s;
                end
                OP_JALR: begin
                    taken_d    = 1'b1;
                    redirect_d = 1'b1;
                    target_d   = jalr_tgt_s;
                end
                OP_BRANCH: begin
                    if (cond_legal_s) begin
                        taken_d    = cond_s;
                        redirect_d = cond_s ^ ex_pred_taken;
                        target_d   = cond_s ? pc_plus_imm_s : pc_plus4_s;
                        bht_upd_s  = 1'b1;
                    end else begin
                        illegal_d  = 1'b1;
                        target_d   = pc_plus4_s;
                    end
                end
                default: begin
                    target_d = pc_plus4_s;
                end
            endcase
        end else begin
            target_d = target_q;
        end
    end

    // Registered resolution result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            taken_q    <= 1'b0;
            redirect_q <= 1'b0;
            illegal_q  <= 1'b0;
            target_q   <= {XLEN{1'b0}};
        end else begin
            valid_q    <= valid_d;
            taken_q    <= taken_d;
            redirect_q <= redirect_d;
            illegal_q  <= illegal_d;
            target_q   <= target_d;
        end
    end

    // Predictor table: weakly not-taken after reset, trained by resolved branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CTR_INIT;
            end
        end else if (bht_upd_s) begin
            bht_q[ex_idx_s] <= ctr_next(bht_q[ex_idx_s], cond_s);
        end else begin
            bht_q[ex_idx_s] <= bht_q[ex_idx_s];
        end
    end

`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mp_q;

    // Conditional-branch and misprediction counters; jumps are excluded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else if (bht_upd_s) begin
            stat_br_q <= stat_br_q + 32'd1;
            stat_mp_q <= stat_mp_q + {31'd0, redirect_d};
        end else begin
            stat_br_q <= stat_br_q;
            stat_mp_q <= stat_mp_q;
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mp_q;
`endif

    assign br_valid    = valid_q;
    assign br_taken    = taken_q;
    assign br_redirect = redirect_q;
    assign br_target   = target_q;
    assign br_illegal  = illegal_q;

endmodule

// File: tb/tb_branch_unit.sv
// Table-driven scoreboard bench for branch_unit with a reference predictor model.
module tb_branch_unit;

    typedef struct {
        logic        valid;
        logic        flush;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        pred;
        logic        e_valid;
        logic        e_taken;
        logic        e_redir;
        logic        e_ill;
        logic        chk_tgt;
        logic [31:0] e_tgt;
    } vec_t;

    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JLR = 7'b1100111;
    localparam logic [6:0] ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic        ex_valid, ex_flush, ex_pred_taken;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
    logic        br_valid, br_taken, br_redirect, br_illegal;
    logic [31:0] br_target;
`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    int   total = 0;
    int   bad   = 0;
    int   bht_m [64];
    int   m_branches = 0;
    int   m_mispred  = 0;
    vec_t sb [$];
    vec_t tbl [17];

    branch_unit dut (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .ex_valid(ex_valid), .ex_flush(ex_flush), .ex_opcode(ex_opcode),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
`ifdef BRANCH_UNIT_STATS_EN
        .stat_branches(stat_branches), .stat_mispred(stat_mispred),
`endif
        .br_valid(br_valid), .br_taken(br_taken), .br_redirect(br_redirect),
        .br_target(br_target), .br_illegal(br_illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic fl, input logic [6:0] op,
                                input logic [2:0] f3, input logic [31:0] pc,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic pred,
                                input logic ev, input logic et, input logic er,
                                input logic ei, input logic ct, input logic [31:0] tgt);
        vec_t r;
        r.valid = v;  r.flush = fl; r.op = op; r.f3 = f3; r.pc = pc;
        r.rs1 = rs1;  r.rs2 = rs2;  r.imm = imm; r.pred = pred;
        r.e_valid = ev; r.e_taken = et; r.e_redir = er; r.e_ill = ei;
        r.chk_tgt = ct; r.e_tgt = tgt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63);
    endfunction

    function automatic logic pred_m(input logic [31:0] pc);
        return (bht_m[idx_of(pc)] >= 2) ? 1'b1 : 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        m_branches = 0;
        m_mispred  = 0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        vec_t e;
        int   k;
        ex_valid = v.valid; ex_flush = v.flush; ex_opcode = v.op; ex_funct3 = v.f3;
        ex_pc = v.pc; ex_rs1 = v.rs1; ex_rs2 = v.rs2; ex_imm = v.imm;
        ex_pred_taken = v.pred; f_pc = v.pc;
        sb.push_back(v);
        #1;
        chk({nm, "_fpre"}, {31'd0, f_pred_taken}, {31'd0, pred_m(v.pc)});
        @(posedge clk);
        #1;
        if (v.valid && !v.flush && v.op == BR && v.f3 != 3'b010 && v.f3 != 3'b011) begin
            k = idx_of(v.pc);
            if (v.e_taken && bht_m[k] < 3) bht_m[k]++;
            if (!v.e_taken && bht_m[k] > 0) bht_m[k]--;
            m_branches++;
            if (v.e_redir) m_mispred++;
        end
        chk({nm, "_fpost"}, {31'd0, f_pred_taken}, {31'd0, pred_m(v.pc)});
        if (sb.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({nm, "_valid"},  {31'd0, br_valid},    {31'd0, e.e_valid});
            chk({nm, "_taken"},  {31'd0, br_taken},    {31'd0, e.e_taken});
            chk({nm, "_redir"},  {31'd0, br_redirect}, {31'd0, e.e_redir});
            chk({nm, "_illeg"},  {31'd0, br_illegal},  {31'd0, e.e_ill});
            if (e.chk_tgt) chk({nm, "_target"}, br_target, e.e_tgt);
        end
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_valid"},  {31'd0, br_valid},    32'd0);
        chk({nm, "_taken"},  {31'd0, br_taken},    32'd0);
        chk({nm, "_redir"},  {31'd0, br_redirect}, 32'd0);
        chk({nm, "_illeg"},  {31'd0, br_illegal},  32'd0);
        chk({nm, "_target"}, br_target,            32'd0);
    endtask

    initial begin
        //              v  fl op   f3      pc            rs1           rs2           imm           pr ev et er ei ct tgt
        tbl[0]  = mk(1, 0, BR,  3'b000, 32'h100,      32'd5,        32'd5,        32'h20,       0, 1, 1, 1, 0, 1, 32'h120);
        tbl[1]  = mk(1, 0, BR,  3'b100, 32'h204,      32'hFFFFFFFF, 32'd1,        32'h40,       1, 1, 1, 0, 0, 1, 32'h244);
        tbl[2]  = mk(1, 0, BR,  3'b110, 32'h204,      32'hFFFFFFFF, 32'd1,        32'h40,       1, 1, 0, 1, 0, 1, 32'h208);
        tbl[3]  = mk(1, 0, JLR, 3'b000, 32'h300,      32'h1001,     32'd0,        32'h10,       0, 1, 1, 1, 0, 1, 32'h1010);
        tbl[4]  = mk(1, 1, JLR, 3'b000, 32'h300,      32'h1001,     32'd0,        32'h10,       0, 0, 0, 0, 0, 1, 32'h1010);
        tbl[5]  = mk(1, 1, BR,  3'b000, 32'h100,      32'd5,        32'd5,        32'h20,       0, 0, 0, 0, 0, 1, 32'h1010);
        tbl[6]  = mk(1, 0, JAL, 3'b000, 32'h400,      32'd0,        32'd0,        32'hFFFFFFF0, 0, 1, 1, 1, 0, 1, 32'h3F0);
        tbl[7]  = mk(1, 0, BR,  3'b001, 32'h10,       32'd1,        32'd2,        32'h8,        0, 1, 1, 1, 0, 1, 32'h18);
        tbl[8]  = mk(1, 0, BR,  3'b101, 32'h20,       32'd1,        32'hFFFFFFFF, 32'h100,      1, 1, 1, 0, 0, 1, 32'h120);
        tbl[9]  = mk(1, 0, BR,  3'b111, 32'h20,       32'd1,        32'hFFFFFFFF, 32'h100,      1, 1, 0, 1, 0, 1, 32'h24);
        tbl[10] = mk(1, 0, BR,  3'b010, 32'h30,       32'd1,        32'd1,        32'h8,        1, 1, 0, 0, 1, 0, 32'h0);
        tbl[11] = mk(1, 0, BR,  3'b011, 32'h30,       32'd1,        32'd1,        32'h8,        0, 1, 0, 0, 1, 0, 32'h0);
        tbl[12] = mk(1, 0, ALU, 3'b000, 32'h500,      32'd1,        32'd1,        32'h8,        1, 1, 0, 0, 0, 1, 32'h504);
        tbl[13] = mk(0, 0, JAL, 3'b000, 32'h600,      32'd0,        32'd0,        32'h8,        0, 0, 0, 0, 0, 1, 32'h504);
        tbl[14] = mk(1, 0, JAL, 3'b000, 32'hFFFFFFF0, 32'd0,        32'd0,        32'h20,       0, 1, 1, 1, 0, 1, 32'h10);
        tbl[15] = mk(1, 0, BR,  3'b000, 32'h40,       32'd3,        32'd4,        32'h80,       0, 1, 0, 0, 0, 1, 32'h44);
        tbl[16] = mk(1, 0, BR,  3'b100, 32'h50,       32'd1,        32'hFFFFFFFF, 32'h8,        0, 1, 0, 0, 0, 1, 32'h54);

        rst = 1'b1; ex_valid = 1'b0; ex_flush = 1'b0; ex_opcode = 7'd0; ex_funct3 = 3'd0;
        ex_pc = 32'd0; ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_imm = 32'd0; ex_pred_taken = 1'b0;
        f_pc = 32'h100;
        model_reset();
        #12;
        chk("reset_fpred", {31'd0, f_pred_taken}, 32'd0);
        chk_outputs_zero("reset");
`ifdef BRANCH_UNIT_STATS_EN
        chk("reset_stat_br", stat_branches, 32'd0);
        chk("reset_stat_mp", stat_mispred,  32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs_zero("post_reset");

        for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Counter saturation and illegal-branch isolation at one index.
        for (int i = 0; i < 3; i++)
            run_vec(mk(1, 0, BR, 3'b001, 32'h6F0, 32'd1, 32'd2, 32'h10, 0, 1, 1, 1, 0, 1, 32'h700),
                    $sformatf("sat_up%0d", i));
        for (int i = 0; i < 4; i++)
            run_vec(mk(1, 0, BR, 3'b001, 32'h6F0, 32'd7, 32'd7, 32'h10, 0, 1, 0, 0, 0, 1, 32'h6F4),
                    $sformatf("sat_dn%0d", i));
        for (int i = 0; i < 2; i++)
            run_vec(mk(1, 0, BR, 3'b001, 32'h6F0, 32'd1, 32'd2, 32'h10, 1, 1, 1, 0, 0, 1, 32'h700),
                    $sformatf("re_up%0d", i));
        run_vec(mk(1, 0, BR, 3'b010, 32'h6F0, 32'd1, 32'd2, 32'h10, 0, 1, 0, 0, 1, 0, 32'h0), "illeg_hold");
        run_vec(mk(1, 0, BR, 3'b001, 32'h6F0, 32'd7, 32'd7, 32'h10, 1, 1, 0, 1, 0, 1, 32'h6F4), "after_illeg");

`ifdef BRANCH_UNIT_STATS_EN
        chk("stat_branches", stat_branches, 32'(m_branches));
        chk("stat_mispred",  stat_mispred,  32'(m_mispred));
`endif

        // Asynchronous reset in the middle of an active resolution.
        ex_valid = 1'b1; ex_flush = 1'b0; ex_opcode = JAL; ex_pc = 32'h800; ex_imm = 32'h40;
        f_pc = 32'h100;
        @(posedge clk);
        #1;
        chk("mid_pre_valid", {31'd0, br_valid}, 32'd1);
        chk("mid_pre_fpred", {31'd0, f_pred_taken}, {31'd0, pred_m(32'h100)});
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_outputs_zero("mid_rst");
        chk("mid_rst_fpred100", {31'd0, f_pred_taken}, 32'd0);
        f_pc = 32'h204;
        #1;
        chk("mid_rst_fpred204", {31'd0, f_pred_taken}, 32'd0);
`ifdef BRANCH_UNIT_STATS_EN
        chk("mid_rst_stat_br", stat_branches, 32'd0);
        chk("mid_rst_stat_mp", stat_mispred,  32'd0);
`endif
        @(posedge clk);
        #1;
        chk("mid_rst_hold_valid", {31'd0, br_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec(tbl[0], "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
